// File: rtl/redmule_mx_store_scheduler.sv
// rtl/redmule_mx_store_scheduler.sv - merges MX value beats and packed shared exponents onto the Z store channel
//
// Value beats go through combinationally, with zero latency, while the tile
// is running. Shared exponents are collected into a pack buffer. The buffer
// is sent as a dedicated exponent beat (out_sel_o = 1) when it holds EXP_PACK
// exponents, or when the last exponent of the tile has been accepted.
//
// Optional feature: define REDMULE_MX_STORE_CNT_EN to enable the saturating
// backpressure counter on stall_cycles_o. Without it the output is tied to 0.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             synchronous clear to IDLE (has priority over start_i)
//   start_i             tile start pulse, accepted in IDLE only
//   tile_beats_i        value beats in the tile, sampled on start
//   val_*               value stream in  (valid/ready/data)
//   exp_*               exponent stream in (valid/ready/data)
//   out_*               store channel out (valid/ready/data/sel)
//   busy_o              high outside IDLE
//   done_o              one-cycle tile completion pulse
//   stall_cycles_o      cycles with out_valid_o && !out_ready_i

module redmule_mx_store_scheduler #(
    parameter int DATAW_ALIGN = 512,
    parameter int EXP_W       = 8,
    parameter int EXP_PACK    = DATAW_ALIGN / EXP_W,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       tile_beats_i,
    input  logic                   val_valid_i,
    output logic                   val_ready_o,
    input  logic [DATAW_ALIGN-1:0] val_data_i,
    input  logic                   exp_valid_i,
    output logic                   exp_ready_o,
    input  logic [EXP_W-1:0]       exp_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATAW_ALIGN-1:0] out_data_o,
    output logic                   out_sel_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [31:0]            stall_cycles_o
);

    // pack_cnt has to be able to hold EXP_PACK itself, not only EXP_PACK-1
    localparam int PACK_W = $clog2(EXP_PACK + 1);
    localparam int BUF_W  = EXP_PACK * EXP_W;
    localparam logic [PACK_W-1:0] PACK_FULL = PACK_W'(EXP_PACK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beats_q;
    logic [CNT_W-1:0]   val_cnt_q;
    logic [CNT_W-1:0]   exp_cnt_q;
    logic [PACK_W-1:0]  pack_cnt_q;
    logic [BUF_W-1:0]   pack_buf_q;

    logic               start_acc;
    logic               val_hs;
    logic               exp_hs;
    logic               flush_hs;
    logic               val_left;
    logic               exp_left;
    logic               pack_room;
    logic [CNT_W-1:0]   val_cnt_nx;
    logic [CNT_W-1:0]   exp_cnt_nx;
    logic [PACK_W-1:0]  pack_cnt_nx;

    assign start_acc = start_i && !clear_i && (state_q == IDLE);
    assign val_hs    = val_valid_i && val_ready_o;
    assign exp_hs    = exp_valid_i && exp_ready_o;
    assign flush_hs  = (state_q == FLUSH) && out_ready_i;
    assign val_left  = val_cnt_q < beats_q;
    assign exp_left  = exp_cnt_q < beats_q;
    assign pack_room = pack_cnt_q < PACK_FULL;

    // Counter values after this cycle's handshakes. The RUN exits look at
    // these so that a fill or the last beat in this cycle is acted on
    // immediately, without an extra idle cycle.
    assign val_cnt_nx  = val_cnt_q + CNT_W'(val_hs);
    assign exp_cnt_nx  = exp_cnt_q + CNT_W'(exp_hs);
    assign pack_cnt_nx = pack_cnt_q + PACK_W'(exp_hs);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = (tile_beats_i != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if ((pack_cnt_nx == PACK_FULL) ||
                        ((exp_cnt_nx == beats_q) && (pack_cnt_nx != '0))) begin
                        state_d = FLUSH;
                    end else if ((val_cnt_nx == beats_q) && (exp_cnt_nx == beats_q) &&
                                 (pack_cnt_nx == '0)) begin
                        state_d = DONE;
                    end
                end
                FLUSH: begin
                    if (out_ready_i) begin
                        state_d = ((val_cnt_q == beats_q) && (exp_cnt_q == beats_q)) ? DONE : RUN;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_sel_o   = 1'b0;
        val_ready_o = 1'b0;
        exp_ready_o = 1'b0;
        busy_o      = (state_q != IDLE);
        // A clear landing on the DONE cycle aborts the tile, so no pulse
        done_o      = (state_q == DONE) && !clear_i;
        unique case (state_q)
            RUN: begin
                out_valid_o = val_valid_i && val_left;
                out_data_o  = val_data_i;
                val_ready_o = out_ready_i && val_left;
                exp_ready_o = exp_left && pack_room;
            end
            FLUSH: begin
                out_valid_o = 1'b1;
                out_sel_o   = 1'b1;
                // Unfilled lanes are already zero: the buffer is cleared on
                // start and after every exponent beat.
                out_data_o  = DATAW_ALIGN'(pack_buf_q);
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tile counters and exponent pack buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beats_q    <= '0;
            val_cnt_q  <= '0;
            exp_cnt_q  <= '0;
            pack_cnt_q <= '0;
            pack_buf_q <= '0;
        end else if (clear_i) begin
            beats_q    <= '0;
            val_cnt_q  <= '0;
            exp_cnt_q  <= '0;
            pack_cnt_q <= '0;
            pack_buf_q <= '0;
        end else if (start_acc) begin
            beats_q    <= tile_beats_i;
            val_cnt_q  <= '0;
            exp_cnt_q  <= '0;
            pack_cnt_q <= '0;
            pack_buf_q <= '0;
        end else begin
            if (val_hs) begin
                val_cnt_q <= val_cnt_nx;
            end
            if (exp_hs) begin
                exp_cnt_q  <= exp_cnt_nx;
                pack_cnt_q <= pack_cnt_nx;
                // Lanes fill in arrival order, starting at lane 0
                for (int i = 0; i < EXP_PACK; i++) begin
                    if (pack_cnt_q == PACK_W'(i)) begin
                        pack_buf_q[i*EXP_W +: EXP_W] <= exp_data_i;
                    end
                end
            end
            // exp_ready_o is low in FLUSH, so this never collides with a write
            if (flush_hs) begin
                pack_cnt_q <= '0;
                pack_buf_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backpressure counter
    // ------------------------------------------------------------------
`ifdef REDMULE_MX_STORE_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (clear_i || start_acc) begin
            stall_q <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_redmule_mx_store_scheduler.sv
// tb/tb_redmule_mx_store_scheduler.sv - scoreboard bench for redmule_mx_store_scheduler
module tb_redmule_mx_store_scheduler;

    localparam int PACK = 4;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         clear_i;
    logic         start_i;
    logic [15:0]  tile_beats_i;
    logic         val_valid_i;
    logic         val_ready_o;
    logic [511:0] val_data_i;
    logic         exp_valid_i;
    logic         exp_ready_o;
    logic [7:0]   exp_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [511:0] out_data_o;
    logic         out_sel_o;
    logic         busy_o;
    logic         done_o;
    logic [31:0]  stall_cycles_o;

    redmule_mx_store_scheduler #(
        .DATAW_ALIGN(512),
        .EXP_W      (8),
        .EXP_PACK   (PACK),
        .CNT_W      (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .tile_beats_i  (tile_beats_i),
        .val_valid_i   (val_valid_i),
        .val_ready_o   (val_ready_o),
        .val_data_i    (val_data_i),
        .exp_valid_i   (exp_valid_i),
        .exp_ready_o   (exp_ready_o),
        .exp_data_i    (exp_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_sel_o     (out_sel_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beats: values in acceptance order, exponent beats built from
    // groups of PACK accepted exponents (last group zero padded).
    logic [511:0] vq[$];
    logic [511:0] eq[$];

    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int v_seen = 0, e_seen = 0, busy_cnt = 0, outv_cnt = 0;
    int seq_val = 0, seq_len = 0;

    int rmode = 1;
    int rprob = 100;
    logic rforce = 1'b1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rmode == 0) out_ready_i = ($urandom_range(99) < rprob);
        else            out_ready_i = rforce;
    end

    // Monitor: samples one time unit after the falling edge
    always @(negedge clk) begin
        #1;
        if (!rst_i) begin
            if (busy_o) busy_cnt++;
            if (out_valid_o) outv_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid_o && out_ready_i) begin
                last_hs_cyc = cyc;
                seq_val = (seq_val << 1) | int'(out_sel_o);
                seq_len++;
                if (!out_sel_o) begin
                    v_seen++;
                    if (vq.size() == 0) chk("val_beat_unexpected", 1, 0);
                    else chk("val_beat_data", out_data_o, vq.pop_front());
                end else begin
                    e_seen++;
                    if (eq.size() == 0) chk("exp_beat_unexpected", 1, 0);
                    else chk("exp_beat_data", out_data_o, eq.pop_front());
                    chk("flush_val_ready", val_ready_o, 0);
                    chk("flush_exp_ready", exp_ready_o, 0);
                end
            end
        end
    end

    task automatic drive_vals(input int n, input int prob, input int delay);
        int i = 0;
        int g = 0;
        logic acc;
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        while (i < n && g < 4000) begin
            if (!val_valid_i && $urandom_range(99) < prob) begin
                val_valid_i = 1'b1;
                for (int k = 0; k < 16; k++) val_data_i[k*32 +: 32] = $urandom();
            end
            @(negedge clk);
            acc = val_valid_i && val_ready_o;
            if (acc) vq.push_back(val_data_i);
            @(posedge clk);
            #1;
            if (acc) begin
                val_valid_i = 1'b0;
                i++;
            end
            g++;
        end
        val_valid_i = 1'b0;
    endtask

    task automatic drive_exps(input int n, input int prob);
        int i = 0;
        int g = 0;
        int lane = 0;
        logic [511:0] grp = '0;
        logic acc;
        while (i < n && g < 4000) begin
            if (!exp_valid_i && $urandom_range(99) < prob) begin
                exp_valid_i = 1'b1;
                exp_data_i  = 8'($urandom());
            end
            @(negedge clk);
            acc = exp_valid_i && exp_ready_o;
            if (acc) begin
                grp[lane*8 +: 8] = exp_data_i;
                lane++;
                i++;
                if (lane == PACK || i == n) begin
                    eq.push_back(grp);
                    grp  = '0;
                    lane = 0;
                end
            end
            @(posedge clk);
            #1;
            if (acc) exp_valid_i = 1'b0;
            g++;
        end
        exp_valid_i = 1'b0;
    endtask

    task automatic run_tile(input int n, input int vprob, input int eprob, input int vdelay);
        int d0, v0, e0, g, start_cyc;
        d0 = done_cnt;
        v0 = v_seen;
        e0 = e_seen;
        start_i      = 1'b1;
        tile_beats_i = 16'(n);
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        fork
            drive_vals(n, vprob, vdelay);
            drive_exps(n, eprob);
        join
        g = 0;
        while (done_cnt == d0 && g < 200) begin
            @(negedge clk);
            #2;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt - d0, 1);
        if (n == 0) chk("done_latency_empty", done_cyc, start_cyc + 1);
        else        chk("done_latency", done_cyc, last_hs_cyc + 1);
        chk("val_beats", v_seen - v0, n);
        chk("exp_beats", e_seen - e0, (n + PACK - 1) / PACK);
        chk("val_queue_left", vq.size(), 0);
        chk("exp_queue_left", eq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, o0, g, s0, e0;
        logic [511:0] hold;
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        start_i      = 1'b0;
        tile_beats_i = '0;
        val_valid_i  = 1'b0;
        val_data_i   = '0;
        exp_valid_i  = 1'b0;
        exp_data_i   = '0;
        out_ready_i  = 1'b1;
        #12;
        chk("rst_val_ready", val_ready_o, 0);
        chk("rst_exp_ready", exp_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_sel", out_sel_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_stall", stall_cycles_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Full tile, both streams always valid, no backpressure
        rmode = 1; rforce = 1'b1;
        seq_val = 0; seq_len = 0;
        run_tile(8, 100, 100, 0);
        chk("seq8_order", seq_val, 10'b0000100001);
        chk("seq8_len", seq_len, 10);

        // Partial last exponent group
        seq_val = 0; seq_len = 0;
        run_tile(6, 100, 100, 0);
        chk("seq6_order", seq_val, 8'b00001001);
        chk("seq6_len", seq_len, 8);

        // Empty tile
        b0 = busy_cnt; o0 = outv_cnt;
        run_tile(0, 100, 100, 0);
        chk("empty_busy_cycles", busy_cnt - b0, 1);
        chk("empty_out_valid", outv_cnt - o0, 0);

        // Exponents arrive well ahead of values; exponent beat stalled 5 cycles
        rforce = 1'b0;
        seq_val = 0; seq_len = 0;
        fork
            run_tile(4, 100, 100, 20);
            begin
                g = 0;
                @(negedge clk);
                #2;
                while (!(out_valid_o && out_sel_o) && g < 50) begin
                    @(negedge clk);
                    #2;
                    g++;
                end
                if (g >= 50) chk("flush_seen", 0, 1);
                chk("stall_before", stall_cycles_o, 0);
                hold = out_data_o;
                for (int k = 0; k < 5; k++) begin
                    chk("stall_out_valid", out_valid_o, 1);
                    chk("stall_data_stable", out_data_o, hold);
                    chk("stall_val_ready", val_ready_o, 0);
                    chk("stall_exp_ready", exp_ready_o, 0);
                    if (k < 4) begin
                        @(negedge clk);
                        #2;
                    end
                end
                rforce = 1'b1;
                @(negedge clk);
                #2;
`ifdef REDMULE_MX_STORE_CNT_EN
                chk("stall_count", stall_cycles_o, 5);
`else
                chk("stall_count_off", stall_cycles_o, 0);
`endif
                repeat (3) @(negedge clk);
                #2;
                chk("exp_ready_all_taken", exp_ready_o, 0);
                chk("busy_waiting_vals", busy_o, 1);
            end
        join
        chk("early_exp_order", seq_val, 5'b10000);
        chk("early_exp_len", seq_len, 5);

        // Clear in the middle of a tile after three value beats
        rforce = 1'b1;
        s0 = done_cnt;
        e0 = e_seen;
        start_i = 1'b1; tile_beats_i = 16'd8;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            val_valid_i = 1'b1;
            for (int w = 0; w < 16; w++) val_data_i[w*32 +: 32] = $urandom();
            vq.push_back(val_data_i);
            @(posedge clk);
            #1;
        end
        val_valid_i = 1'b0;
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        @(negedge clk);
        #2;
        chk("clear_busy", busy_o, 0);
        chk("clear_out_valid", out_valid_o, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("clear_no_done", done_cnt - s0, 0);
        chk("clear_no_exp_beat", e_seen - e0, 0);
        chk("clear_vals_drained", vq.size(), 0);
        run_tile(2, 100, 100, 0);

        // Randomized tiles with random valids and backpressure
        rmode = 0;
        for (int t = 0; t < 30; t++) begin
            rprob = $urandom_range(40, 100);
            run_tile($urandom_range(0, 13), $urandom_range(30, 100), $urandom_range(30, 100),
                     $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
